// File: rtl/entrada_handshake.sv
// Operator input handshake: synchronizes and debounces the confirm button, then latches the switches as a 32-bit operand.
// Define ENTRADA_SINAL_EN to sign-extend Chaves from bit 7; by default it is zero-extended.
module entrada_handshake #(
  parameter int unsigned DEBOUNCE_CICLOS = 50000,
  parameter int unsigned LARGURA_CONT    = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [7:0]  Chaves,
  input  logic        ChaveConfirma,
  input  logic        PedidoEntrada,
  output logic [31:0] DadoEntrada,
  output logic        DadoValido,
  output logic        LEDIN
);

  localparam int unsigned LIMITE = (DEBOUNCE_CICLOS > 0) ? DEBOUNCE_CICLOS - 1 : 0;
  localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;

  typedef enum logic [2:0] {
    OCIOSO,
    AGUARDA_PRESSAO,
    FILTRA_PRESSAO,
    ENTREGA,
    FILTRA_SOLTURA
  } estado_t;

  estado_t                 estado, prox_estado;
  logic [LARGURA_CONT-1:0] contador, prox_contador, contador_inc;
  logic                    sinc_1, botao_sinc;
  logic                    janela_completa, carrega;
  logic [31:0]             dado_estendido;

  // The window closes on the cycle whose increment would bring the counter to LIMITE,
  // so exactly DEBOUNCE_CICLOS stable synchronized samples are required.
  assign janela_completa = (33'(contador) + 33'd1) >= 33'(LIMITE);
  assign contador_inc    = (contador == CONT_MAX) ? contador : contador + 1'b1;

`ifdef ENTRADA_SINAL_EN
  assign dado_estendido = {{24{Chaves[7]}}, Chaves};
`else
  assign dado_estendido = {24'h000000, Chaves};
`endif

  always_comb begin
    prox_estado   = estado;
    prox_contador = contador;
    carrega       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (PedidoEntrada) prox_estado = AGUARDA_PRESSAO;
      end
      AGUARDA_PRESSAO: begin
        if (!PedidoEntrada) begin
          prox_estado = OCIOSO;
        end else if (botao_sinc) begin
          prox_estado   = FILTRA_PRESSAO;
          prox_contador = '0;
        end
      end
      FILTRA_PRESSAO: begin
        if (!PedidoEntrada) begin
          prox_estado = OCIOSO;
        end else if (!botao_sinc) begin
          prox_estado = AGUARDA_PRESSAO;
        end else if (janela_completa) begin
          prox_estado = ENTREGA;
          carrega     = 1'b1;
        end else begin
          prox_contador = contador_inc;
        end
      end
      ENTREGA: begin
        prox_estado   = FILTRA_SOLTURA;
        prox_contador = '0;
      end
      FILTRA_SOLTURA: begin
        // Any bounce back to pressed restarts the release window, so one press delivers once.
        if (botao_sinc) begin
          prox_contador = '0;
        end else if (janela_completa) begin
          prox_estado = OCIOSO;
        end else begin
          prox_contador = contador_inc;
        end
      end
      default: begin
        prox_estado   = OCIOSO;
        prox_contador = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      estado      <= OCIOSO;
      contador    <= '0;
      sinc_1      <= 1'b0;
      botao_sinc  <= 1'b0;
      DadoEntrada <= 32'h0;
    end else begin
      estado     <= prox_estado;
      contador   <= prox_contador;
      sinc_1     <= ChaveConfirma;
      botao_sinc <= sinc_1;
      if (carrega) DadoEntrada <= dado_estendido;
    end
  end

  // Gated by Reset so a reset landing on the ENTREGA cycle never lets the CPU retire.
  assign DadoValido = (estado == ENTREGA) && Reset;
  assign LEDIN      = (estado == AGUARDA_PRESSAO) || (estado == FILTRA_PRESSAO);

endmodule

// File: tb/tb_entrada_handshake.sv
// Directed bench for entrada_handshake with a 4-cycle debounce window.
// Expected operands follow ENTRADA_SINAL_EN when it is defined for the build.
module tb_entrada_handshake;

  logic        CLK;
  logic        Reset;
  logic [7:0]  Chaves;
  logic        ChaveConfirma;
  logic        PedidoEntrada;
  logic [31:0] DadoEntrada;
  logic        DadoValido;
  logic        LEDIN;

  int nchecks = 0;
  int nfails  = 0;
  int pulsos  = 0;

  entrada_handshake #(
    .DEBOUNCE_CICLOS(4),
    .LARGURA_CONT(16)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .Chaves(Chaves),
    .ChaveConfirma(ChaveConfirma),
    .PedidoEntrada(PedidoEntrada),
    .DadoEntrada(DadoEntrada),
    .DadoValido(DadoValido),
    .LEDIN(LEDIN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ext(input logic [7:0] v);
`ifdef ENTRADA_SINAL_EN
    return {{24{v[7]}}, v};
`else
    return {24'h000000, v};
`endif
  endfunction

  task automatic applyStimulus(input logic rst, input logic pedido, input logic confirma,
                               input logic [7:0] chaves);
    Reset         = rst;
    PedidoEntrada = pedido;
    ChaveConfirma = confirma;
    Chaves        = chaves;
  endtask

  // Advances n edges, sampling 1 time unit after each and counting delivery strobes.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (DadoValido === 1'b1) pulsos++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nfails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick(2);
    checkOutput("reset_ledin", 32'(LEDIN), 32'd0);
    checkOutput("reset_valido", 32'(DadoValido), 32'd0);
    checkOutput("reset_dado", DadoEntrada, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1);
    checkOutput("idle_ledin", 32'(LEDIN), 32'd0);

    $display("[TB] basic delivery");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
    tick(1);
    checkOutput("basic_prompt", 32'(LEDIN), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA5);
    pulsos = 0;
    tick(5);
    checkOutput("basic_prompt_hold", 32'(LEDIN), 32'd1);
    checkOutput("basic_no_early", 32'(pulsos), 32'd0);
    tick(1);
    checkOutput("basic_valido", 32'(DadoValido), 32'd1);
    checkOutput("basic_dado", DadoEntrada, ext(8'hA5));
    checkOutput("basic_ledin_off", 32'(LEDIN), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5);
    tick(1);
    checkOutput("basic_strobe_end", 32'(DadoValido), 32'd0);
    checkOutput("basic_dado_hold", DadoEntrada, ext(8'hA5));
    tick(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
    tick(6);
    checkOutput("basic_one_pulse", 32'(pulsos), 32'd1);
    checkOutput("basic_idle", 32'(LEDIN), 32'd0);

    $display("[TB] glitch rejection");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    tick(1);
    pulsos = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h3C);
    tick(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    tick(6);
    checkOutput("glitch_no_pulse", 32'(pulsos), 32'd0);
    checkOutput("glitch_prompt", 32'(LEDIN), 32'd1);
    checkOutput("glitch_dado_hold", DadoEntrada, ext(8'hA5));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h3C);
    tick(6);
    checkOutput("glitch_then_valido", 32'(DadoValido), 32'd1);
    checkOutput("glitch_then_dado", DadoEntrada, ext(8'h3C));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    tick(12);
    checkOutput("glitch_one_pulse", 32'(pulsos), 32'd1);
    checkOutput("glitch_new_request", 32'(LEDIN), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
    tick(1);
    checkOutput("glitch_cancel", 32'(LEDIN), 32'd0);

    $display("[TB] abort while filtering");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
    tick(1);
    checkOutput("abort_prompt", 32'(LEDIN), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
    tick(3);
    checkOutput("abort_filtering", 32'(LEDIN), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h77);
    pulsos = 0;
    tick(1);
    checkOutput("abort_ledin", 32'(LEDIN), 32'd0);
    checkOutput("abort_valido", 32'(DadoValido), 32'd0);
    tick(6);
    checkOutput("abort_no_pulse", 32'(pulsos), 32'd0);
    checkOutput("abort_dado_hold", DadoEntrada, ext(8'h3C));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
    tick(4);

    $display("[TB] single delivery per press");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h81);
    tick(1);
    pulsos = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h81);
    tick(40);
    checkOutput("long_one_pulse", 32'(pulsos), 32'd1);
    checkOutput("long_dado", DadoEntrada, ext(8'h81));
    checkOutput("long_ledin", 32'(LEDIN), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h81);
    tick(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h12);
    tick(10);
    checkOutput("short_release_no_pulse", 32'(pulsos), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h12);
    tick(8);
    checkOutput("release_rearm", 32'(LEDIN), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h12);
    tick(6);
    checkOutput("second_valido", 32'(DadoValido), 32'd1);
    checkOutput("second_dado", DadoEntrada, ext(8'h12));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h12);
    tick(10);
    checkOutput("second_two_pulses", 32'(pulsos), 32'd2);
    checkOutput("second_idle", 32'(LEDIN), 32'd0);

    $display("[TB] reset during ENTREGA");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
    tick(5);
    checkOutput("rst_pre_entrega", 32'(DadoValido), 32'd0);
    tick(1);
    checkOutput("rst_in_entrega", 32'(DadoValido), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    #1;
    checkOutput("rst_strobe_gated", 32'(DadoValido), 32'd0);
    tick(1);
    checkOutput("rst_valido", 32'(DadoValido), 32'd0);
    checkOutput("rst_ledin", 32'(LEDIN), 32'd0);
    checkOutput("rst_dado", DadoEntrada, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A);
    tick(4);
    checkOutput("rst_idle", 32'(LEDIN), 32'd0);

    $display("[TB] button held before request");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3);
    tick(4);
    checkOutput("held_idle", 32'(LEDIN), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hC3);
    pulsos = 0;
    tick(1);
    checkOutput("held_prompt", 32'(LEDIN), 32'd1);
    tick(3);
    checkOutput("held_no_instant", 32'(pulsos), 32'd0);
    checkOutput("held_valido_low", 32'(DadoValido), 32'd0);
    tick(1);
    checkOutput("held_valido", 32'(DadoValido), 32'd1);
    checkOutput("held_dado", DadoEntrada, ext(8'hC3));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hC3);
    tick(10);
    checkOutput("held_one_pulse", 32'(pulsos), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule
